bcm_paint_scheduler: RTL

- Sequences the 24-bit painter for a 64x64 BCM LED panel (two 32-row halves, scanned as row pairs).
- Walks frame / bit-plane / row-pair / column and drives painter coordinates and counters.
- Slices one bit plane out of each returned RGB24 pixel and writes 3-bit pixel words into the downstream row buffer.
- Handshakes with the row shifter at row granularity and owns the frame counter used for panel animation.

---
 rtl/bcm_paint_scheduler.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bcm_paint_scheduler.sv
// BCM paint scheduler for a 64x64 panel scanned as row pairs: walks frame/plane/row/column,
// drives the painter, and slices one bit plane of each returned pixel into the row buffer.
module bcm_paint_scheduler #(
  parameter int COLS          = 64,
  parameter int ROWS          = 32,
  parameter int PLANES        = 8,
  parameter int PAINT_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        buf_free,
  output logic [9:0]                  p_frame,
  output logic [7:0]                  p_subframe,
  output logic [$clog2(COLS)-1:0]     p_x,
  output logic [$clog2(ROWS):0]       p_y,
  input  logic [23:0]                 p_rgb24,
  output logic                        wr_en,
  output logic [$clog2(COLS):0]       wr_addr,
  output logic [2:0]                  wr_data,
  output logic                        row_done,
  output logic [$clog2(ROWS)-1:0]     row_addr,
  output logic [$clog2(PLANES)-1:0]   row_plane,
  output logic                        frame_done
);
  localparam int XW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int PW = $clog2(PLANES);
  localparam int IW = XW + 1;
  localparam int DW = (PAINT_LATENCY > 1) ? $clog2(PAINT_LATENCY) : 1;

  typedef enum logic [1:0] {S_WAIT, S_FILL, S_DRAIN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx;
  logic [DW-1:0]   drain_cnt;
  logic [RW-1:0]   row;
  logic [PW-1:0]   plane;
  logic [9:0]      frame;
  logic            issue;
  logic            idx_last, drain_last, row_last, plane_last;
  logic [7:0]      r_ch, g_ch, b_ch;

  logic [PAINT_LATENCY:1]          vld_pipe;
  logic [PAINT_LATENCY:1][IW-1:0]  addr_pipe;

  assign idx_last   = &idx;
  assign drain_last = (drain_cnt == DW'(PAINT_LATENCY - 1));
  assign row_last   = (row == RW'(ROWS - 1));
  assign plane_last = (plane == PW'(PLANES - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= S_WAIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:  if (buf_free)   state_nxt = S_FILL;
      S_FILL:  if (idx_last)   state_nxt = S_DRAIN;
      S_DRAIN: if (drain_last) state_nxt = S_DONE;
      S_DONE:                  state_nxt = S_WAIT;
      default:                 state_nxt = S_WAIT;
    endcase
  end

  always_comb begin
    issue      = 1'b0;
    p_x        = '0;
    p_y        = '0;
    row_done   = 1'b0;
    row_addr   = '0;
    row_plane  = '0;
    frame_done = 1'b0;
    case (state)
      S_FILL: begin
        issue = 1'b1;
        p_x   = idx[XW-1:0];
        p_y   = {idx[IW-1], row};
      end
      S_DONE: begin
        row_done   = 1'b1;
        row_addr   = row;
        row_plane  = plane;
        frame_done = row_last && plane_last;
      end
      default: ;
    endcase
  end

  // Plane and frame only move in DONE, so the painter sees them steady for a whole row.
  assign p_frame    = frame;
  assign p_subframe = 8'(plane);

  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      drain_cnt <= '0;
      row       <= '0;
      plane     <= '0;
      frame     <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          idx       <= '0;
          drain_cnt <= '0;
        end
        S_FILL:  idx       <= idx + 1'b1;
        S_DRAIN: drain_cnt <= drain_cnt + 1'b1;
        S_DONE: begin
          row <= row + 1'b1;
          if (row_last) begin
            plane <= plane_last ? '0 : plane + 1'b1;
            if (plane_last) frame <= frame + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Issued address travels alongside the painter so it lines up with p_rgb24.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
    end else begin
      vld_pipe[1]  <= issue;
      addr_pipe[1] <= idx;
      for (int s = 2; s <= PAINT_LATENCY; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        addr_pipe[s] <= addr_pipe[s-1];
      end
    end
  end

  assign r_ch    = p_rgb24[7:0];
  assign g_ch    = p_rgb24[15:8];
  assign b_ch    = p_rgb24[23:16];
  assign wr_en   = vld_pipe[PAINT_LATENCY];
  assign wr_addr = wr_en ? addr_pipe[PAINT_LATENCY] : '0;
  assign wr_data = wr_en ? {b_ch[plane], g_ch[plane], r_ch[plane]} : 3'b000;
endmodule
